pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer_pkg.sv | 47 ++++
 rtl/pipeline_sequencer_hazard.sv | 39 +++
 rtl/pipeline_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer_pkg
//
// Shared definitions for the pipeline sequencer.  The state encoding is kept
// here so that the debug unit can decode o_state with the same names the
// sequencer uses internally, and so that both sides agree on the default
// number of drain cycles.
//
// Contents:
//   seq_state_e           - FSM state encoding, 3 bits wide
//   SEQ_STATE_BITS        - width of the encoded state (width of o_state)
//   DRAIN_CYCLES_DEFAULT  - cycles needed to retire a HALT from ID through WB
//   seqIsActive()         - true for the states in which the pipeline executes
//   seqIsCounting()       - true for the states that count toward o_cycles
// ---------------------------------------------------------------------------
package pipeline_sequencer_pkg;

   localparam int SEQ_STATE_BITS = 3;

   // A HALT sitting in ID still has to pass through EX, MEM and WB before
   // the program is fully retired, hence three cycles by default.
   localparam int DRAIN_CYCLES_DEFAULT = 3;

   // Explicit encodings: the debug unit decodes these values from o_state,
   // so they must never be renumbered silently.
   typedef enum logic [SEQ_STATE_BITS-1:0] {
      IDLE      = 3'd0,
      RUN       = 3'd1,
      STEP_WAIT = 3'd2,
      STEP      = 3'd3,
      DRAIN     = 3'd4,
      DONE      = 3'd5
   } seq_state_e;

   // RUN and STEP are the states in which instructions are fetched and the
   // hazard inputs are honoured.
   function automatic logic seqIsActive(input seq_state_e s);
      return (s == RUN) || (s == STEP);
   endfunction

   // The cycle counter tracks every cycle in which the pipeline moves,
   // which includes the autonomous drain after a HALT.
   function automatic logic seqIsCounting(input seq_state_e s);
      return (s == RUN) || (s == STEP) || (s == DRAIN);
   endfunction

endpackage : pipeline_sequencer_pkg

// File: rtl/pipeline_sequencer_hazard.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Purely combinational load-use hazard detector.  A load in EX whose
// destination register is read by the instruction in ID cannot forward its
// data in time, so the instruction in ID must wait one cycle.  Register 0 is
// hard-wired to zero and never creates a dependency.
//
// Ports:
//   ex_memread_i  - EX stage holds a load
//   ex_rt_i       - destination register of the load in EX
//   id_rs_i       - first source register of the instruction in ID
//   id_rt_i       - second source register of the instruction in ID
//   stall_o       - load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int RBITS = 5
) (
   input  logic             ex_memread_i,
   input  logic [RBITS-1:0] ex_rt_i,
   input  logic [RBITS-1:0] id_rs_i,
   input  logic [RBITS-1:0] id_rt_i,
   output logic             stall_o
);

   logic rsMatch;
   logic rtMatch;
   logic destNonZero;

   // Compare the load destination against both ID sources; a write to the
   // zero register is discarded by the register file, so it cannot hazard.
   always_comb begin
      rsMatch     = (ex_rt_i == id_rs_i);
      rtMatch     = (ex_rt_i == id_rt_i);
      destNonZero = (ex_rt_i != '0);
      stall_o     = ex_memread_i && destNonZero && (rsMatch || rtMatch);
   end

endmodule : hazard_unit

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Run-control sequencer for a five-stage pipeline.  It starts the pipeline in
// continuous or single-step mode, turns load-use hazards into a stall plus an
// ID/EX bubble, turns taken branches into an IF/ID bubble, and on a HALT
// drains the instructions already in flight before reporting completion.
//
// Parameters:
//   NBITS         - width of the active-cycle counter
//   RBITS         - width of a register name
//   DRAIN_CYCLES  - cycles needed to retire a HALT from ID through WB
//
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start             - start request (rising edge), i_step_mode sampled
//                         with it: 0 = continuous, 1 = single-step
//   i_step              - step request (rising edge)
//   i_halt              - HALT decoded in ID
//   i_branch_taken      - branch/jump resolved taken in ID
//   i_ID_rs, i_ID_rt    - source registers in ID
//   i_EX_rt             - load destination in EX
//   i_EX_memread        - EX holds a load
//   o_pc_en .. o_memwb_en     - per-stage register write enables
//   o_ifid_flush, o_idex_flush - bubble insertion into IF/ID and ID/EX
//   o_done              - program retired (registered)
//   o_state             - current FSM state (registered)
//   o_cycles            - active-cycle count (registered, wraps)
// ---------------------------------------------------------------------------
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int NBITS        = 32,
   parameter int RBITS        = 5,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic                      i_step_mode,
   input  logic                      i_step,
   input  logic                      i_halt,
   input  logic                      i_branch_taken,
   input  logic [RBITS-1:0]          i_ID_rs,
   input  logic [RBITS-1:0]          i_ID_rt,
   input  logic [RBITS-1:0]          i_EX_rt,
   input  logic                      i_EX_memread,
   output logic                      o_pc_en,
   output logic                      o_ifid_en,
   output logic                      o_idex_en,
   output logic                      o_exmem_en,
   output logic                      o_memwb_en,
   output logic                      o_ifid_flush,
   output logic                      o_idex_flush,
   output logic                      o_done,
   output logic [SEQ_STATE_BITS-1:0] o_state,
   output logic [NBITS-1:0]          o_cycles
);

   // The drain counter must be able to hold DRAIN_CYCLES itself.
   localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

   seq_state_e       state_q,    state_d;
   logic [CNT_W-1:0] drainCnt_q, drainCnt_d;
   logic [NBITS-1:0] cycles_q,   cycles_d;
   logic             done_q,     done_d;
   logic             startPrev_q;
   logic             stepPrev_q;

   logic startEdge;
   logic stepEdge;
   logic stall;
   logic active;

   // Load-use detection lives in its own unit so it can be reused by the
   // forwarding logic later without dragging the FSM along.
   hazard_unit #(
      .RBITS (RBITS)
   ) u_hazard (
      .ex_memread_i (i_EX_memread),
      .ex_rt_i      (i_EX_rt),
      .id_rs_i      (i_ID_rs),
      .id_rt_i      (i_ID_rt),
      .stall_o      (stall)
   );

   // Edge detection against last cycle's input: a button held high for many
   // cycles only produces a single request.
   always_comb begin
      startEdge = i_start & ~startPrev_q;
      stepEdge  = i_step  & ~stepPrev_q;
      active    = seqIsActive(state_q);
   end

   // Next-state and output logic.  Stage enables and flushes react to the
   // hazard inputs in the same cycle; everything the outside world reads as
   // status (done, state, cycle count) comes from registers.
   always_comb begin
      state_d      = state_q;
      drainCnt_d   = drainCnt_q;
      cycles_d     = cycles_q;
      done_d       = done_q;
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_en    = 1'b0;
      o_exmem_en   = 1'b0;
      o_memwb_en   = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;

      case (state_q)
         IDLE: begin
            if (startEdge) begin
               state_d = i_step_mode ? STEP_WAIT : RUN;
            end
         end

         STEP_WAIT: begin
            if (stepEdge) begin
               state_d = STEP;
            end
         end

         RUN, STEP: begin
            o_pc_en    = 1'b1;
            o_ifid_en  = 1'b1;
            o_idex_en  = 1'b1;
            o_exmem_en = 1'b1;
            o_memwb_en = 1'b1;
            if (stall) begin
               // Hold PC and IF/ID, push a bubble into EX.  A branch or HALT
               // in ID is re-examined next cycle once the load has moved on.
               o_pc_en      = 1'b0;
               o_ifid_en    = 1'b0;
               o_idex_flush = 1'b1;
            end else begin
               if (i_branch_taken) begin
                  o_ifid_flush = 1'b1;
               end
               if (i_halt) begin
                  // Stop fetching; the HALT itself moves on into ID/EX.
                  o_pc_en   = 1'b0;
                  o_ifid_en = 1'b0;
               end
            end

            if (!stall && i_halt) begin
               state_d    = DRAIN;
               drainCnt_d = DRAIN_LOAD;
            end else if (state_q == STEP) begin
               state_d = STEP_WAIT;
            end
         end

         DRAIN: begin
            // Fetch stays frozen and ID/EX only receives bubbles, while the
            // back end keeps retiring what is already in flight.
            o_idex_en    = 1'b1;
            o_exmem_en   = 1'b1;
            o_memwb_en   = 1'b1;
            o_idex_flush = 1'b1;
            if (drainCnt_q <= CNT_W'(1)) begin
               state_d    = DONE;
               drainCnt_d = '0;
            end else begin
               drainCnt_d = drainCnt_q - CNT_W'(1);
            end
         end

         DONE: begin
            state_d = DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (seqIsCounting(state_q)) begin
         cycles_d = cycles_q + NBITS'(1);
      end

      done_d = (state_d == DONE);

      // Reset must freeze the pipeline immediately, not a cycle later.
      if (i_rst) begin
         o_pc_en      = 1'b0;
         o_ifid_en    = 1'b0;
         o_idex_en    = 1'b0;
         o_exmem_en   = 1'b0;
         o_memwb_en   = 1'b0;
         o_ifid_flush = 1'b0;
         o_idex_flush = 1'b0;
      end
   end

   // State, counters and edge-detect history.  Reset wins from any state,
   // including part-way through a drain or a single step.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         drainCnt_q  <= '0;
         cycles_q    <= '0;
         done_q      <= 1'b0;
         startPrev_q <= 1'b0;
         stepPrev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         drainCnt_q  <= drainCnt_d;
         cycles_q    <= cycles_d;
         done_q      <= done_d;
         startPrev_q <= i_start;
         stepPrev_q  <= i_step;
      end
   end

   always_comb begin
      o_state  = state_q;
      o_done   = done_q;
      o_cycles = cycles_q;
   end

endmodule : pipeline_sequencer
